// File: rtl/biquad_avg_decimator_pkg.sv
// Shared widths, sample type and output-reduction helper for biquad_avg_decimator.
package filt_pkg;

  localparam int unsigned SAMPLE_W = 8;
  localparam int unsigned RED_W    = 64;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    logic                    ovf;
    logic signed [RED_W-1:0] val;
  } red_t;

  function automatic int unsigned fir_w(input int unsigned data_w, input int unsigned coef_w);
    return data_w + coef_w + 2;
  endfunction

  function automatic int unsigned sum_w(input int unsigned fw, input int unsigned avg_log2);
    return fw + avg_log2;
  endfunction

  // Out-of-range is the same test for both modes: in wrap mode it is exactly
  // "upper bits are not a sign-extension", and the caller keeps the low bits.
  function automatic red_t reduce(input logic signed [RED_W-1:0] v,
                                  input int unsigned out_w,
                                  input logic sat);
    logic signed [RED_W-1:0] one;
    logic signed [RED_W-1:0] maxv;
    logic signed [RED_W-1:0] minv;
    red_t r;
    one   = RED_W'(1);
    maxv  = (one <<< (out_w - 1)) - one;
    minv  = -maxv - one;
    r.ovf = (v > maxv) || (v < minv);
    r.val = v;
    if (sat && (v > maxv)) begin
      r.val = maxv;
    end else if (sat && (v < minv)) begin
      r.val = minv;
    end
    return r;
  endfunction

endpackage

// File: rtl/biquad_avg_decimator_avg_ring.sv
// avg_ring: ring of the last 2^LOG2 pushed values with an incrementally updated running sum.
module avg_ring
  import filt_pkg::*;
#(
  parameter int unsigned W    = 14,
  parameter int unsigned LOG2 = 6
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               clear,
  input  logic                               push,
  input  logic signed [W-1:0]                push_data,
  output logic signed [sum_w(W, LOG2)-1:0]   next_sum,
  output logic signed [sum_w(W, LOG2)-1:0]   average
);

  localparam int unsigned SW     = sum_w(W, LOG2);
  localparam int unsigned PW     = (LOG2 > 0) ? LOG2 : 1;
  localparam int unsigned RDEPTH = 1 << PW;

  // With LOG2=0 the pointer stays at 0 and only entry 0 is ever touched.
  logic signed [W-1:0]  ring_q [RDEPTH];
  logic signed [W-1:0]  ring_d [RDEPTH];
  logic        [PW-1:0] wp_q, wp_d;
  logic signed [SW-1:0] sum_q, sum_d;
  logic signed [W-1:0]  oldest;

  always_comb begin
    oldest   = ring_q[wp_q];
    next_sum = sum_q + SW'(push_data) - SW'(oldest);
    average  = next_sum >>> LOG2;
  end

  always_comb begin
    ring_d = ring_q;
    wp_d   = wp_q;
    sum_d  = sum_q;
    if (clear) begin
      for (int unsigned i = 0; i < RDEPTH; i++) begin
        ring_d[i] = '0;
      end
      wp_d  = '0;
      sum_d = '0;
    end else if (push) begin
      ring_d[wp_q] = push_data;
      wp_d         = (LOG2 == 0) ? '0 : wp_q + 1'b1;
      sum_d        = next_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RDEPTH; i++) begin
        ring_q[i] <= '0;
      end
      wp_q  <= '0;
      sum_q <= '0;
    end else begin
      ring_q <= ring_d;
      wp_q   <= wp_d;
      sum_q  <= sum_d;
    end
  end

endmodule

// File: rtl/biquad_avg_decimator.sv
// biquad_avg_decimator: 3-tap FIR -> running moving average -> decimated valid/ready output.
// Define BIQUAD_AVG_SAT_EN to saturate out-of-range averages instead of wrapping them.
module biquad_avg_decimator
  import filt_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned COEF_W   = 4,
  parameter int          C0       = 1,
  parameter int          C1       = -2,
  parameter int          C2       = 1,
  parameter int unsigned AVG_LOG2 = 6,
  parameter int unsigned DECIM    = 64,
  parameter int unsigned OUT_W    = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     overflow
);

  localparam int unsigned FW    = fir_w(DATA_W, COEF_W);
  localparam int unsigned SW    = sum_w(FW, AVG_LOG2);
  localparam int unsigned CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

`ifdef BIQUAD_AVG_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  localparam logic signed [COEF_W-1:0] K0 = COEF_W'(C0);
  localparam logic signed [COEF_W-1:0] K1 = COEF_W'(C1);
  localparam logic signed [COEF_W-1:0] K2 = COEF_W'(C2);

  logic signed [DATA_W-1:0] x1_q, x1_d, x2_q, x2_d;
  logic        [CNT_W-1:0]  cnt_q, cnt_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0]  out_data_q, out_data_d;
  logic                     overflow_q, overflow_d;
  logic signed [FW-1:0]     fir;
  logic signed [SW-1:0]     ring_sum, ring_avg, avg_sel;
  logic                     accept;
  red_t                     red;

  assign in_ready  = !clear && !(out_valid_q && !out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign overflow  = overflow_q;

  always_comb begin
    fir = FW'(K0) * FW'(in_data) + FW'(K1) * FW'(x1_q) + FW'(K2) * FW'(x2_q);
  end

  avg_ring #(
    .W    (FW),
    .LOG2 (AVG_LOG2)
  ) u_ring (
    .clk       (CLK),
    .rst_n     (RST),
    .clear     (clear),
    .push      (accept),
    .push_data (fir),
    .next_sum  (ring_sum),
    .average   (ring_avg)
  );

  // Without averaging the updated sum is already the result.
  assign avg_sel = (AVG_LOG2 == 0) ? ring_sum : ring_avg;

  always_comb begin
    x1_d        = x1_q;
    x2_d        = x2_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    overflow_d  = overflow_q;
    red         = reduce(RED_W'(avg_sel), OUT_W, SAT);
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (clear) begin
      x1_d        = '0;
      x2_d        = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
    end else if (accept) begin
      x2_d = x1_q;
      x1_d = in_data;
      // A fresh result overrides a same-cycle drain of the previous one.
      if (cnt_q == CNT_LAST) begin
        cnt_d       = '0;
        out_valid_d = 1'b1;
        out_data_d  = OUT_W'(red.val);
        overflow_d  = overflow_q | red.ovf;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      x1_q        <= '0;
      x2_q        <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule

// File: tb/tb_biquad_avg_decimator.sv
// Bench for biquad_avg_decimator: default instance (dut 0) and DECIM=1/AVG_LOG2=0 instance (dut 1).
module tb_biquad_avg_decimator;

  logic              clk;
  logic              rst_n;
  logic              clear     [2];
  logic              in_valid  [2];
  logic              in_ready  [2];
  logic signed [7:0] in_data   [2];
  logic              out_valid [2];
  logic              out_ready [2];
  logic signed [7:0] out_data  [2];
  logic              overflow  [2];

  biquad_avg_decimator u_a (
    .CLK(clk), .RST(rst_n), .clear(clear[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .overflow(overflow[0])
  );

  biquad_avg_decimator #(.DECIM(1), .AVG_LOG2(0)) u_b (
    .CLK(clk), .RST(rst_n), .clear(clear[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .overflow(overflow[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int d; int data; int ovf; } exp_t;
  typedef struct { int din; int dout; } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   mx1[2], mx2[2], mcnt[2], mn[2], mov[2];
  int   fh[2][64];
  bit   stop_rdy;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  function automatic int exp_red(input int v, output int o);
    int w;
    o = ((v > 127) || (v < -128)) ? 1 : 0;
`ifdef BIQUAD_AVG_SAT_EN
    w = (v > 127) ? 127 : ((v < -128) ? -128 : v);
`else
    w = v & 255;
    if (w >= 128) w = w - 256;
`endif
    return w;
  endfunction

  // Reference: re-sums the last 2^L FIR outputs each time (zeros before the first sample).
  task automatic model_accept(input int d, input int x);
    int f, s, L, dec, depth, o;
    exp_t e;
    L     = (d == 0) ? 6 : 0;
    dec   = (d == 0) ? 64 : 1;
    depth = 1 << L;
    f     = x - 2 * mx1[d] + mx2[d];
    fh[d][mn[d] % 64] = f;
    mn[d]++;
    s = 0;
    for (int k = 0; k < depth; k++) begin
      if (mn[d] - 1 - k >= 0) s += fh[d][(mn[d] - 1 - k) % 64];
    end
    mx2[d] = mx1[d];
    mx1[d] = x;
    if (mcnt[d] == dec - 1) begin
      mcnt[d] = 0;
      e.d     = d;
      e.data  = exp_red(s >>> L, o);
      mov[d]  = mov[d] | o;
      e.ovf   = mov[d];
      sb.push_back(e);
    end else begin
      mcnt[d]++;
    end
  endtask

  task automatic model_clear(input int d);
    exp_t keep[$];
    mx1[d] = 0; mx2[d] = 0; mcnt[d] = 0; mn[d] = 0;
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].d != d) keep.push_back(sb[i]);
    end
    sb = keep;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      model_clear(d);
      mov[d] = 0;
    end
    sb.delete();
  endtask

  // Called in the posedge+1 phase; returns in the posedge+1 phase after the accepting edge.
  task automatic accept(input int d, input int x);
    bit done = 1'b0;
    in_valid[d] = 1'b1;
    in_data[d]  = 8'(x);
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (in_ready[d]) begin
        model_accept(d, x);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid[d] = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout dut%0d: got in_ready=0 for 200 cycles required 1", d);
    end
  endtask

  task automatic do_clear(input int d);
    clear[d] = 1'b1;
    model_clear(d);
    @(negedge clk);
    chk("clear_in_ready", in_ready[d], 0);
    @(posedge clk); #1;
    clear[d] = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_n && out_valid[d] && out_ready[d]) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out dut%0d: got %0d required no output", d, out_data[d]);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_data", out_data[d], mon_e.data);
          chk("sb_overflow", overflow[d], mon_e.ovf);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[4];
    tbl[0] = '{100, 100};
`ifdef BIQUAD_AVG_SAT_EN
    tbl[1] = '{0, -128};
`else
    tbl[1] = '{0, 56};
`endif
    tbl[2] = '{0, 100};
    tbl[3] = '{0, 0};

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      clear[d] = 1'b0; in_valid[d] = 1'b0; in_data[d] = '0; out_ready[d] = 1'b1;
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_out_valid", out_valid[d], 0);
      chk("reset_out_data", out_data[d], 0);
      chk("reset_overflow", overflow[d], 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", in_ready[0], 1);

    // Constant 10 for 128 accepts: result one cycle after the 64th accept.
    for (int i = 0; i < 128; i++) begin
      accept(0, 10);
      if (i == 62) chk("const_no_valid_63", out_valid[0], 0);
      if (i == 63) begin
        chk("const_valid_64", out_valid[0], 1);
        chk("const_data", out_data[0], 0);
      end
    end
    drain();

    // Ramp 0..63: window sum 1, 1>>>6 = 0.
    do_clear(0);
    for (int i = 0; i < 64; i++) accept(0, i);
    chk("ramp_data", out_data[0], 0);
    chk("ramp_overflow", overflow[0], 0);
    drain();

    // Impulse through DECIM=1, AVG_LOG2=0.
    for (int i = 0; i < 4; i++) begin
      accept(1, tbl[i].din);
      chk("impulse_valid", out_valid[1], 1);
      chk("impulse_data", out_data[1], tbl[i].dout);
    end
    chk("impulse_overflow", overflow[1], 1);
    drain();

    // Back-pressure: first result held, input stalled, then released.
    out_ready[1] = 1'b0;
    accept(1, 5);
    chk("hold_first", out_data[1], 5);
    fork
      accept(1, 5);
      begin
        repeat (10) begin
          @(negedge clk);
          chk("hold_in_ready", in_ready[1], 0);
          chk("hold_valid", out_valid[1], 1);
          chk("hold_data", out_data[1], 5);
        end
        @(posedge clk); #1;
        out_ready[1] = 1'b1;
      end
    join
    for (int i = 0; i < 6; i++) accept(1, 5);
    drain();

    // Clear after 30 accepts restarts the decimation count.
    for (int i = 0; i < 30; i++) accept(0, 10);
    do_clear(0);
    for (int i = 0; i < 64; i++) begin
      accept(0, 10);
      if (i == 62) chk("clear_no_valid_63", out_valid[0], 0);
      if (i == 63) begin
        chk("clear_valid_64", out_valid[0], 1);
        chk("clear_data", out_data[0], 0);
      end
    end
    drain();

    // Pending result (x63-x62 = 255, >>>6 = 3) dropped by asynchronous reset.
    out_ready[0] = 1'b0;
    for (int i = 0; i < 62; i++) accept(0, 0);
    accept(0, -128);
    accept(0, 127);
    chk("pend_valid", out_valid[0], 1);
    chk("pend_data", out_data[0], 3);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid[0], 0);
    chk("async_out_data", out_data[0], 0);
    chk("async_overflow_b", overflow[1], 0);
    chk("async_out_valid_b", out_valid[1], 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready[0] = 1'b1;

    // Fresh random stream with random back-pressure against the model.
    stop_rdy = 1'b0;
    fork
      begin
        for (int i = 0; i < 130; i++) accept(0, int'($urandom_range(0, 255)) - 128);
        stop_rdy = 1'b1;
      end
      begin
        while (!stop_rdy) begin
          @(posedge clk); #1;
          out_ready[0] = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready[0] = 1'b1;
    drain();

    for (int i = 0; i < 40; i++) accept(1, int'($urandom_range(0, 255)) - 128);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
